// File: rtl/tankb_rom_loader.sv
// Purpose: byte stream to ROM/PROM download bus bridge; holds the game in reset while loading.
// Latency: a byte accepted at edge N drives dn_wr for WR_HOLD cycles from N+1; release at N+WR_HOLD+RELEASE_DELAY after the last byte.
// Backpressure: s_ready is high only while waiting for a byte, so one byte is taken per WR_HOLD+1 cycles at most.
//
// Ports:
//   CLK_18M, RESET_n        : clock (rising edge) and asynchronous active-low reset
//   start                   : begin/restart a load, highest priority in every state
//   s_data/s_valid/s_ready  : inbound image byte stream
//   dn_addr/dn_data/dn_wr   : download bus towards the core ROMs
//   game_reset_n            : low keeps the core in reset until a full image is loaded
//   busy/done/overflow      : status; done and overflow are sticky until the next start
module tankb_rom_loader #(
    parameter int TOTAL_BYTES   = 10496,
    parameter int WR_HOLD       = 2,
    parameter int RELEASE_DELAY = 16
) (
    input  logic        CLK_18M,
    input  logic        RESET_n,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        game_reset_n,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [13:0] LAST_ADDR  = 14'(TOTAL_BYTES - 1);
    localparam logic [3:0]  HOLD_INIT  = 4'(WR_HOLD - 1);
    localparam logic [7:0]  DELAY_INIT = 8'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_SETTLE
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] addr_q, addr_d;
    logic [13:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic        dn_wr_q, dn_wr_d;
    logic [3:0]  hold_q, hold_d;
    logic [7:0]  delay_q, delay_d;
    logic        game_rst_n_q, game_rst_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    always_ff @(posedge CLK_18M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_wr_q      <= 1'b0;
            hold_q       <= '0;
            delay_q      <= '0;
            game_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_wr_q      <= dn_wr_d;
            hold_q       <= hold_d;
            delay_q      <= delay_d;
            game_rst_n_q <= game_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dn_wr_d      = dn_wr_q;
        hold_d       = hold_q;
        delay_d      = delay_q;
        game_rst_n_d = game_rst_n_q;
        busy_d       = busy_q;
        done_d       = done_q;
        ovf_d        = ovf_q;

        if (start) begin
            // Abort whatever is in flight; dn_addr/dn_data keep their last values.
            state_d      = ST_ACCEPT;
            addr_d       = '0;
            dn_wr_d      = 1'b0;
            done_d       = 1'b0;
            ovf_d        = 1'b0;
            game_rst_n_d = 1'b0;
            busy_d       = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Bytes after a completed image are an error; before any load they are ignored.
                    if (s_valid && done_q) begin
                        ovf_d = 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    if (s_valid) begin
                        dn_data_d = s_data;
                        dn_addr_d = addr_q;
                        dn_wr_d   = 1'b1;
                        hold_d    = HOLD_INIT;
                        state_d   = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (hold_q == 4'd0) begin
                        dn_wr_d = 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            delay_d = DELAY_INIT;
                            state_d = ST_SETTLE;
                        end else begin
                            addr_d  = addr_q + 14'd1;
                            state_d = ST_ACCEPT;
                        end
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
                ST_SETTLE: begin
                    if (s_valid) begin
                        ovf_d = 1'b1;
                    end
                    if (delay_q == 8'd0) begin
                        game_rst_n_d = 1'b1;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        delay_d = delay_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = (state_q == ST_ACCEPT);
    assign dn_addr      = dn_addr_q;
    assign dn_data      = dn_data_q;
    assign dn_wr        = dn_wr_q;
    assign game_reset_n = game_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_tankb_rom_loader.sv
// Bench for tankb_rom_loader: a default-size instance and a tiny one (4 bytes, 1-cycle strobe,
// 1-cycle release) share one randomized stimulus; a timestamp-based model predicts every output.
module tb_tankb_rom_loader;

    localparam int T0 = 10496;
    localparam int H0 = 2;
    localparam int R0 = 16;
    localparam int T1 = 4;
    localparam int H1 = 1;
    localparam int R1 = 1;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;

    logic [1:0]       rdy, wr, grn, bsy, dn, ov;
    logic [1:0][13:0] da;
    logic [1:0][7:0]  dd;

    tankb_rom_loader #(.TOTAL_BYTES(T0), .WR_HOLD(H0), .RELEASE_DELAY(R0)) u_big (
        .CLK_18M(clk), .RESET_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[0]), .dn_addr(da[0]), .dn_data(dd[0]), .dn_wr(wr[0]),
        .game_reset_n(grn[0]), .busy(bsy[0]), .done(dn[0]), .overflow(ov[0])
    );

    tankb_rom_loader #(.TOTAL_BYTES(T1), .WR_HOLD(H1), .RELEASE_DELAY(R1)) u_small (
        .CLK_18M(clk), .RESET_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[1]), .dn_addr(da[1]), .dn_data(dd[1]), .dn_wr(wr[1]),
        .game_reset_n(grn[1]), .busy(bsy[1]), .done(dn[1]), .overflow(ov[1])
    );

    function automatic int tot(input int k);
        return (k == 0) ? T0 : T1;
    endfunction
    function automatic int hold(input int k);
        return (k == 0) ? H0 : H1;
    endfunction
    function automatic int rdel(input int k);
        return (k == 0) ? R0 : R1;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
            if (errors >= 50) summary_and_finish();
        end
    endtask

    // ---------------- behavioural model (edge-number timestamps) ----------------
    int          cyc;
    bit          m_load[2];
    int          m_nacc[2];
    int          m_wrend[2];
    int          m_lastacc[2];
    int          m_start_e[2];
    int          m_rel_e[2];
    logic        m_done[2], m_ovf[2], m_busy[2], m_grn[2];
    logic [13:0] m_addr[2];
    logic [7:0]  m_data[2];

    task automatic model_reset(input int k);
        m_load[k]    = 1'b0;
        m_nacc[k]    = 0;
        m_wrend[k]   = 0;
        m_lastacc[k] = -100;
        m_done[k]    = 1'b0;
        m_ovf[k]     = 1'b0;
        m_busy[k]    = 1'b0;
        m_grn[k]     = 1'b0;
        m_addr[k]    = '0;
        m_data[k]    = '0;
    endtask

    task automatic model_edge(input int k);
        bit oc;
        oc = s_valid && ((m_load[k] && m_nacc[k] == tot(k) && cyc > m_wrend[k]) ||
                         (!m_load[k] && m_done[k]));
        if (start) begin
            m_load[k]    = 1'b1;
            m_nacc[k]    = 0;
            m_done[k]    = 1'b0;
            m_ovf[k]     = 1'b0;
            m_grn[k]     = 1'b0;
            m_busy[k]    = 1'b1;
            m_wrend[k]   = cyc;
            m_lastacc[k] = -100;
            m_start_e[k] = cyc;
        end else begin
            if (oc) m_ovf[k] = 1'b1;
            if (m_load[k] && m_nacc[k] < tot(k) && cyc > m_wrend[k] && s_valid) begin
                m_addr[k]    = 14'(m_nacc[k]);
                m_data[k]    = s_data;
                m_nacc[k]    = m_nacc[k] + 1;
                m_lastacc[k] = cyc;
                m_wrend[k]   = cyc + hold(k);
            end else if (m_load[k] && m_nacc[k] == tot(k) && cyc == m_wrend[k] + rdel(k)) begin
                m_load[k]  = 1'b0;
                m_busy[k]  = 1'b0;
                m_done[k]  = 1'b1;
                m_grn[k]   = 1'b1;
                m_rel_e[k] = cyc;
            end
        end
    endtask

    initial begin
        cyc = 0;
        for (int k = 0; k < 2; k++) model_reset(k);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) model_reset(k);
            end else begin
                cyc++;
                for (int k = 0; k < 2; k++) model_edge(k);
            end
        end
    end

    function automatic logic [27:0] exp_vec(input int k);
        logic r, w;
        r = m_load[k] && (m_nacc[k] < tot(k)) && (cyc >= m_wrend[k]);
        w = (cyc < m_lastacc[k] + hold(k));
        return {r, w, m_grn[k], m_busy[k], m_done[k], m_ovf[k], m_addr[k], m_data[k]};
    endfunction

    // ---------------- compare process + strobe monitor ----------------
    int          pulses[2], minw[2], maxw[2], curw[2];
    logic        prevw[2];
    logic [13:0] first_a[2];
    bit          first_seen[2];

    task automatic clr_mon();
        for (int k = 0; k < 2; k++) begin
            pulses[k]     = 0;
            minw[k]       = 9999;
            maxw[k]       = 0;
            curw[k]       = 0;
            prevw[k]      = 1'b0;
            first_seen[k] = 1'b0;
            first_a[k]    = '1;
        end
    endtask

    initial begin
        clr_mon();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d cyc%0d {rdy,wr,grn,busy,done,ovf,addr,data}", k, cyc),
                    64'({rdy[k], wr[k], grn[k], bsy[k], dn[k], ov[k], da[k], dd[k]}),
                    64'(exp_vec(k)));
                if (wr[k] && !prevw[k]) begin
                    pulses[k]++;
                    curw[k] = 1;
                    if (!first_seen[k]) begin
                        first_seen[k] = 1'b1;
                        first_a[k]    = da[k];
                    end
                end else if (wr[k] && prevw[k]) begin
                    curw[k]++;
                end else if (!wr[k] && prevw[k]) begin
                    if (curw[k] < minw[k]) minw[k] = curw[k];
                    if (curw[k] > maxw[k]) maxw[k] = curw[k];
                end
                prevw[k] = wr[k];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_pulse(input int n);
        start = 1'b1;
        repeat (n) @(posedge clk);
        #1 clr_mon();
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset game_reset_n dut%0d", k), 64'(grn[k]), 64'(0));
            chk($sformatf("reset dn_wr dut%0d", k), 64'(wr[k]), 64'(0));
            chk($sformatf("reset s_ready dut%0d", k), 64'(rdy[k]), 64'(0));
            chk($sformatf("reset busy dut%0d", k), 64'(bsy[k]), 64'(0));
            chk($sformatf("reset done dut%0d", k), 64'(dn[k]), 64'(0));
            chk($sformatf("reset dn_addr dut%0d", k), 64'(da[k]), 64'(0));
        end
        rst_n = 1'b1;

        // Bytes offered before any load are ignored without flagging overflow.
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle never-loaded overflow", 64'(ov[1]), 64'(0));
        chk("idle never-loaded s_ready", 64'(rdy[1]), 64'(0));
        s_valid = 1'b0;

        // Random loads with gaps, multi-cycle start and one mid-load restart.
        for (int it = 0; it < 8; it++) begin
            start_pulse($urandom_range(1, 3));
            for (int c = 0; c < 40; c++) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 8'($urandom);
                start   = (it == 3 && c == 5);
                @(negedge clk);
            end
            start   = 1'b0;
            s_valid = 1'b0;
            @(negedge clk);
            if (m_done[1]) begin
                chk("small release after last accept (model)", 64'(m_rel_e[1] - m_lastacc[1]), 64'(2));
                chk("small done after load", 64'(dn[1]), 64'(1));
            end
        end

        // Tiny image with s_valid held: accepts every 2 cycles, 1-cycle strobes.
        s_valid = 1'b1;
        start_pulse(1);
        guard = 0;
        while (!m_done[1] && guard < 40) begin
            s_data = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        chk("small load completes in budget", 64'(m_done[1]), 64'(1));
        chk("small start-to-release (model)", 64'(m_rel_e[1] - m_start_e[1]), 64'(9));
        chk("small strobe count", 64'(pulses[1]), 64'(4));
        chk("small strobe min width", 64'(minw[1]), 64'(1));
        chk("small strobe max width", 64'(maxw[1]), 64'(1));
        chk("small last dn_addr", 64'(da[1]), 64'(3));
        chk("small first dn_addr", 64'(first_a[1]), 64'(0));

        // Asynchronous reset asserted mid-WRITE, off the clock edge.
        start_pulse(1);
        guard = 0;
        while (!(m_nacc[1] == 2 && cyc < m_lastacc[1] + H1) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("small reached WRITE before reset", 64'(wr[1]), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async reset dn_wr", 64'(wr[1]), 64'(0));
        chk("async reset game_reset_n", 64'(grn[1]), 64'(0));
        chk("async reset busy", 64'(bsy[1]), 64'(0));
        chk("async reset dn_addr", 64'(da[1]), 64'(0));
        chk("async reset big busy", 64'(bsy[0]), 64'(0));
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);

        // Default image: random gaps up to byte 0x1234, then restart.
        start_pulse(1);
        guard = 0;
        while (m_nacc[0] < 'h1234 && guard < 30000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        chk("big reached byte 0x1234", 64'(m_nacc[0] >= 'h1234), 64'(1));
        s_valid = 1'b0;
        start_pulse(1);
        chk("restart game_reset_n", 64'(grn[0]), 64'(0));
        chk("restart done", 64'(dn[0]), 64'(0));
        chk("restart busy", 64'(bsy[0]), 64'(1));

        // Full image with s_valid held and s_data = addr[7:0]; s_valid stays high afterwards.
        s_valid = 1'b1;
        guard = 0;
        while (!m_done[0] && guard < 40000) begin
            s_data = 8'(m_nacc[0]);
            @(negedge clk);
            guard++;
        end
        chk("big load completes in budget", 64'(m_done[0]), 64'(1));
        chk("big start-to-release (model)", 64'(m_rel_e[0] - m_start_e[0]), 64'(10496 * 3 + 16));
        chk("big release after last accept (model)", 64'(m_rel_e[0] - m_lastacc[0]), 64'(18));
        chk("big first write addr after restart", 64'(first_a[0]), 64'(0));
        chk("big strobe count", 64'(pulses[0]), 64'(10496));
        chk("big strobe min width", 64'(minw[0]), 64'(2));
        chk("big strobe max width", 64'(maxw[0]), 64'(2));
        chk("big last dn_addr", 64'(da[0]), 64'(14'h28FF));
        chk("big last dn_data", 64'(dd[0]), 64'(8'hFF));
        chk("big game_reset_n released", 64'(grn[0]), 64'(1));
        chk("big busy cleared", 64'(bsy[0]), 64'(0));
        chk("big overflow from settle", 64'(ov[0]), 64'(1));
        repeat (5) @(negedge clk);
        chk("big no extra strobes", 64'(pulses[0]), 64'(10496));
        chk("big s_ready low after image", 64'(rdy[0]), 64'(0));

        // Next start clears the sticky flags.
        s_valid = 1'b0;
        start_pulse(1);
        chk("start clears overflow", 64'(ov[0]), 64'(0));
        chk("start clears done", 64'(dn[0]), 64'(0));
        repeat (3) @(negedge clk);
        summary_and_finish();
    end

endmodule
